// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: owns the fetch PC, issues sequential imem requests
// and holds them in an in-order queue until decode consumes them.
module fetch_queue_stage #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_plus4
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    // Headroom: back-to-back redirects can stack stale responses beyond DEPTH.
    localparam int DW = CW + 2;

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  q_pc    [DEPTH];
    logic [XLEN-1:0]  q_instr [DEPTH];
    logic [DEPTH-1:0] q_filled;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW-1:0]    fill;
    logic [CW-1:0]    occ;
    logic [CW-1:0]    pend;
    logic [DW-1:0]    drop;

    logic            issue;
    logic            rsp_fill;
    logic            rsp_drop;
    logic            deq;
    logic [DW-1:0]   drop_sum;
    logic [DW-1:0]   drop_next;
    logic [XLEN-1:0] target;

    assign imem_req_valid = !redirect_valid && (occ < CW'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign issue    = imem_req_valid && imem_req_ready;
    assign rsp_drop = imem_rsp_valid && (drop != '0);
    assign rsp_fill = imem_rsp_valid && (drop == '0) && (pend != '0);

    assign dec_valid    = (occ != '0) && q_filled[head];
    assign deq          = dec_valid && dec_ready;
    assign dec_instr    = dec_valid ? q_instr[head] : '0;
    assign dec_pc       = dec_valid ? q_pc[head] : '0;
    assign dec_pc_plus4 = dec_valid ? q_pc[head] + XLEN'(4) : '0;

    // Every unfilled entry still has a response coming back that must die.
    assign drop_sum  = drop + DW'(pend);
    assign drop_next = drop_sum - DW'(imem_rsp_valid && (drop_sum != '0));
    assign target    = {redirect_pc[XLEN-1:2], redirect_pc[1:0] & 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= PC_RESET;
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            occ      <= '0;
            pend     <= '0;
            drop     <= '0;
            q_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= target;
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            occ      <= '0;
            pend     <= '0;
            q_filled <= '0;
            drop     <= drop_next;
        end else begin
            if (issue) begin
                q_pc[tail]     <= fetch_pc;
                q_filled[tail] <= 1'b0;
                tail           <= tail + AW'(1);
                fetch_pc       <= fetch_pc + XLEN'(4);
            end
            if (rsp_fill) begin
                q_instr[fill]  <= imem_rsp_data;
                q_filled[fill] <= 1'b1;
                fill           <= fill + AW'(1);
            end
            if (rsp_drop) begin
                drop <= drop - DW'(1);
            end
            if (deq) begin
                head <= head + AW'(1);
            end
            occ  <= occ + CW'(issue) - CW'(deq);
            pend <= pend + CW'(issue) - CW'(rsp_fill);
        end
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: variable-latency in-order memory model plus
// a scoreboard of accepted fetches compared at every decode handshake.
module tb_fetch_queue_stage;

    localparam int XLEN = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] PC_RST = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;

    fetch_queue_stage #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .PC_RESET(PC_RST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .dec_valid(dec_valid),
        .dec_ready(dec_ready),
        .dec_instr(dec_instr),
        .dec_pc(dec_pc),
        .dec_pc_plus4(dec_pc_plus4)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_pc[$];
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] exp_next;
    int          acc_cnt = 0;
    int          deq_cnt = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rdy_rand = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // In-order memory: handshakes decided by values stable at negedge.
    always begin
        bit          s_rst;
        bit          f_req;
        bit          f_rsp;
        logic [31:0] a;
        @(negedge clk);
        s_rst = rst;
        f_req = !rst && imem_req_valid && imem_req_ready;
        f_rsp = imem_rsp_valid;
        a     = imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (s_rst || rst) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (f_rsp && mq_addr.size() > 0) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (f_req) begin
                mq_addr.push_back(a);
                mq_due.push_back(cyc - 1 + $urandom_range(lat_max, lat_min));
                sb_pc.push_back(a);
                acc_cnt++;
            end
        end
        imem_rsp_valid = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
        imem_rsp_data  = imem_rsp_valid ? enc(mq_addr[0]) : 32'h0;
        imem_req_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    // Decode-side monitor: every handshake must match the scoreboard.
    always @(negedge clk) begin
        if (!rst && !dec_valid) begin
            chk("idle_zero", dec_pc | dec_instr | dec_pc_plus4, 32'h0);
        end
        if (!rst && !redirect_valid && dec_valid && dec_ready) begin
            chk("sb_nonempty", 32'(sb_pc.size() != 0), 32'h1);
            chk("pc_stream", dec_pc, exp_next);
            chk("pc_plus4", dec_pc_plus4, exp_next + 32'h4);
            chk("instr", dec_instr, enc(exp_next));
            if (sb_pc.size() != 0) begin
                chk("sb_pc", dec_pc, sb_pc.pop_front());
            end
            exp_next = exp_next + 32'h4;
            deq_cnt++;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sb_pc.delete();
        acc_cnt  = 0;
        exp_next = PC_RST;
        rst      = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = t;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        sb_pc.delete();
        exp_next = {t[31:2], 2'b00};
    endtask

    task automatic wait_dec(input int n);
        int i = 0;
        @(negedge clk);
        while (!dec_valid && i < n) begin
            @(negedge clk);
            i++;
        end
        chk("dec_wait", 32'(dec_valid), 32'h1);
    endtask

    initial begin
        logic [31:0] held;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        exp_next       = PC_RST;

        repeat (2) @(negedge clk);
        chk("rst_dec_valid", 32'(dec_valid), 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h1);
        chk("rst_req_addr", imem_req_addr, PC_RST);

        // Streaming with 1-cycle memory
        do_reset();
        @(negedge clk);
        chk("c0_req_addr", imem_req_addr, PC_RST);
        chk("c0_dec_valid", 32'(dec_valid), 32'h0);
        @(negedge clk);
        chk("c1_dec_valid", 32'(dec_valid), 32'h0);
        @(negedge clk);
        chk("c2_dec_valid", 32'(dec_valid), 32'h1);
        chk("c2_dec_pc", dec_pc, PC_RST);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stream_valid", 32'(dec_valid), 32'h1);
        end

        // Back-pressure from decode fills the queue
        dec_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        chk("full_acc", 32'(acc_cnt), 32'(DEPTH));
        chk("full_req_valid", 32'(imem_req_valid), 32'h0);
        chk("full_dec_pc", dec_pc, PC_RST);
        held = dec_instr;
        @(negedge clk);
        chk("hold_instr", dec_instr, held);
        chk("hold_acc", 32'(acc_cnt), 32'(DEPTH));
        @(posedge clk);
        #1 dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("drain_valid", 32'(dec_valid), 32'h1);
        end

        // Redirect with stale responses in flight
        lat_min = 3;
        lat_max = 3;
        repeat (12) @(negedge clk);
        redirect_to(32'h0000_2002);
        @(negedge clk);
        chk("rd_req_addr", imem_req_addr, 32'h0000_2000);
        chk("rd_dec_valid1", 32'(dec_valid), 32'h0);
        @(negedge clk);
        chk("rd_dec_valid2", 32'(dec_valid), 32'h0);
        wait_dec(12);
        chk("rd_dec_pc", dec_pc, 32'h0000_2000);

        // Redirect colliding with a response and a dequeue
        lat_min = 1;
        lat_max = 1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        @(negedge clk);
        chk("col_rsp", 32'(imem_rsp_valid), 32'h1);
        chk("col_dec", 32'(dec_valid), 32'h1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        sb_pc.delete();
        exp_next = 32'h0000_3000;
        @(negedge clk);
        chk("col_empty", 32'(dec_valid), 32'h0);
        chk("col_req_addr", imem_req_addr, 32'h0000_3000);
        @(negedge clk);
        @(negedge clk);
        chk("col_dec_valid", 32'(dec_valid), 32'h1);
        chk("col_dec_pc", dec_pc, 32'h0000_3000);

        // Wrap at the top of the address space
        repeat (4) @(negedge clk);
        redirect_to(32'hFFFF_FFFC);
        wait_dec(10);
        chk("wrap_pc", dec_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", dec_pc_plus4, 32'h0);
        @(negedge clk);
        chk("wrap_next", dec_pc, 32'h0);

        // Random memory ready, latency and decode ready
        rdy_rand = 1;
        lat_min  = 1;
        lat_max  = 4;
        deq_cnt  = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1 dec_ready = 1'($urandom_range(3, 0) != 0);
        end
        chk("rand_progress", 32'(deq_cnt > 60), 32'h1);

        // Asynchronous reset mid-operation
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_dec_valid", 32'(dec_valid), 32'h0);
        chk("arst_req_addr", imem_req_addr, PC_RST);
        rdy_rand  = 0;
        dec_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sb_pc.delete();
        exp_next = PC_RST;
        rst      = 1'b0;
        wait_dec(10);
        chk("arst_dec_pc", dec_pc, PC_RST);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
